// File: rtl/blank_window_gen_if.sv
// Sample bus and trigger strobes between bus extraction, the blanking stage and bus insertion.
// The master drives triggers and input words; the slave returns output words and blank flags.
interface blank_window_gen_if #(
    parameter int NUM_CHANNELS    = 2,
    parameter int PAR_SAMPLES     = 8,
    parameter int BITS_PER_SAMPLE = 16
);
    localparam int BUS_W = NUM_CHANNELS * PAR_SAMPLES * BITS_PER_SAMPLE;

    logic [NUM_CHANNELS-1:0] trig_rise;
    logic [BUS_W-1:0]        s_data;
    logic [BUS_W-1:0]        m_data;
    logic [NUM_CHANNELS-1:0] m_blank;

    modport master (
        output trig_rise,
        output s_data,
        input  m_data,
        input  m_blank
    );

    modport slave (
        input  trig_rise,
        input  s_data,
        output m_data,
        output m_blank
    );
endinterface

// File: rtl/blank_window_gen.sv
// Per-channel trigger-relative blanking window with zero/hold/constant fill and status counters.
// Fixed one-cycle latency from s_data to m_data/m_blank; streaming, no backpressure.
module blank_window_gen #(
    parameter int NUM_CHANNELS    = 2,
    parameter int PAR_SAMPLES     = 8,
    parameter int BITS_PER_SAMPLE = 16,
    parameter int CNT_WIDTH       = 24
) (
    input  logic                         data_clk_i,
    input  logic                         data_rst_i,
    input  logic [NUM_CHANNELS-1:0]      cfg_enable_i,
    input  logic [1:0]                   cfg_mode_i,
    input  logic [BITS_PER_SAMPLE-1:0]   cfg_fill_i,
    input  logic [CNT_WIDTH-1:0]         cfg_offset_i,
    input  logic [CNT_WIDTH-1:0]         cfg_length_i,
    input  logic                         cfg_retrig_i,
    blank_window_gen_if.slave            bus,
    output logic [NUM_CHANNELS*16-1:0]   stat_windows_o,
    output logic [NUM_CHANNELS*16-1:0]   stat_dropped_o
);
    localparam int LANE_W = PAR_SAMPLES * BITS_PER_SAMPLE;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [15:0]          STAT_MAX = 16'hFFFF;
    localparam logic [1:0]           MODE_HOLD  = 2'b01;
    localparam logic [1:0]           MODE_CONST = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        state_t                     state;
        logic [CNT_WIDTH-1:0]       dcnt;
        logic [CNT_WIDTH-1:0]       lcnt;
        logic                       first;
        logic [1:0]                 mode_q;
        logic [BITS_PER_SAMPLE-1:0] fill_q;
        logic [BITS_PER_SAMPLE-1:0] hold_q;
        logic [15:0]                win_cnt;
        logic [15:0]                drop_cnt;
        logic [LANE_W-1:0]          data_q;
        logic                       blank_q;

        logic                       en;
        logic                       trig;
        logic                       busy;
        logic                       accept;
        logic                       drop;
        logic                       blank_now;
        logic                       win_start;
        logic [1:0]                 mode_eff;
        logic [BITS_PER_SAMPLE-1:0] fill_eff;
        logic [BITS_PER_SAMPLE-1:0] fill_lane;
        logic [LANE_W-1:0]          in_word;

        always_comb begin
            en        = cfg_enable_i[c];
            trig      = bus.trig_rise[c];
            in_word   = bus.s_data[c*LANE_W +: LANE_W];
            busy      = (state != ST_IDLE);
            accept    = trig && en && (!busy || cfg_retrig_i);
            drop      = trig && en && busy && !cfg_retrig_i;
            blank_now = 1'b0;
            win_start = 1'b0;
            // A freshly accepted trigger overrides whatever window was running.
            if (accept) begin
                if ((cfg_length_i != '0) && (cfg_offset_i == '0)) begin
                    blank_now = 1'b1;
                    win_start = 1'b1;
                end
            end else if (en && (state == ST_ACTIVE)) begin
                blank_now = 1'b1;
                win_start = first;
            end
            mode_eff = accept ? cfg_mode_i : mode_q;
            fill_eff = accept ? cfg_fill_i : fill_q;
            case (mode_eff)
                MODE_HOLD:  fill_lane = hold_q;
                MODE_CONST: fill_lane = fill_eff;
                default:    fill_lane = '0;
            endcase
        end

        always_ff @(posedge data_clk_i) begin
            if (data_rst_i) begin
                state    <= ST_IDLE;
                dcnt     <= '0;
                lcnt     <= '0;
                first    <= 1'b0;
                mode_q   <= '0;
                fill_q   <= '0;
                hold_q   <= '0;
                win_cnt  <= '0;
                drop_cnt <= '0;
                data_q   <= '0;
                blank_q  <= 1'b0;
            end else begin
                if (!en) begin
                    state <= ST_IDLE;
                    first <= 1'b0;
                end else if (accept) begin
                    mode_q <= cfg_mode_i;
                    fill_q <= cfg_fill_i;
                    first  <= 1'b0;
                    if (cfg_length_i == '0) begin
                        state <= ST_IDLE;
                    end else if (cfg_offset_i == '0) begin
                        // Trigger cycle already blanked the first word.
                        if (cfg_length_i == CNT_ONE) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_ACTIVE;
                            lcnt  <= cfg_length_i - CNT_ONE;
                        end
                    end else if (cfg_offset_i == CNT_ONE) begin
                        state <= ST_ACTIVE;
                        lcnt  <= cfg_length_i;
                        first <= 1'b1;
                    end else begin
                        // The trigger cycle counts as the first delay cycle.
                        state <= ST_DELAY;
                        dcnt  <= cfg_offset_i - CNT_ONE;
                        lcnt  <= cfg_length_i;
                    end
                end else begin
                    case (state)
                        ST_DELAY: begin
                            if (dcnt <= CNT_ONE) begin
                                state <= ST_ACTIVE;
                                first <= 1'b1;
                                dcnt  <= '0;
                            end else begin
                                dcnt <= dcnt - CNT_ONE;
                            end
                        end
                        ST_ACTIVE: begin
                            first <= 1'b0;
                            if (lcnt <= CNT_ONE) begin
                                state <= ST_IDLE;
                                lcnt  <= '0;
                            end else begin
                                lcnt <= lcnt - CNT_ONE;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end

                if (!blank_now) begin
                    hold_q <= in_word[LANE_W-1 -: BITS_PER_SAMPLE];
                end
                if (win_start && (win_cnt != STAT_MAX)) begin
                    win_cnt <= win_cnt + 16'd1;
                end
                if (drop && (drop_cnt != STAT_MAX)) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
                blank_q <= blank_now;
                data_q  <= blank_now ? {PAR_SAMPLES{fill_lane}} : in_word;
            end
        end

        assign bus.m_data[c*LANE_W +: LANE_W] = data_q;
        assign bus.m_blank[c]                 = blank_q;
        assign stat_windows_o[c*16 +: 16]     = win_cnt;
        assign stat_dropped_o[c*16 +: 16]     = drop_cnt;
    end
endmodule
